// File: rtl/boron_enc_scheduler_pkg.sv
// Shared types and widths for the BORON encryption scheduler.
// State encodings are 3 bits wide to leave room for future states.
package boron_pkg;

  localparam int BORON_BLK_W = 64;
  localparam int BORON_KEY_W = 80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/boron_enc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request found
// scanning upward from (rr_ptr+1) mod NREQ, returning one-hot grant and index.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    // Scan farthest-first so the nearest requester after rr_ptr wins last.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        grant_idx        = IDX_W'(idx);
        grant            = '0;
        grant[grant_idx] = 1'b1;
        grant_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/boron_enc_scheduler.sv
// Round-robin scheduler sharing one BORON core among NREQ requesters.
// Optional WAIT-state timeout abort is enabled by defining BORON_SCHED_TIMEOUT_EN.
module boron_enc_scheduler
  import boron_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*64-1:0]      req_plain,
  input  logic [NREQ*80-1:0]      req_key,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [63:0]             rsp_cipher,
  output logic                    rsp_err,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [63:0]             core_plain,
  output logic [79:0]             core_key,
  input  logic [63:0]             core_cipher,
  input  logic                    core_done,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("boron_enc_scheduler: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [BORON_BLK_W-1:0] core_plain_q, core_plain_d;
  logic [BORON_KEY_W-1:0] core_key_q, core_key_d;
  logic                   core_reset_q, core_reset_d;
  logic                   core_start_q, core_start_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [BORON_BLK_W-1:0] rsp_cipher_q, rsp_cipher_d;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             grant_en;
  logic             accept;
  logic             tmo_hit;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // core_reset_q is only high in IDLE on the first cycle after reset release,
  // which keeps req_ready low while reset is asserted.
  assign grant_en  = (state_q == ST_IDLE) && !core_reset_q;
  assign accept    = grant_en && grant_vld;
  assign req_ready = grant_en ? grant : '0;

  // State register
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      core_plain_q <= '0;
      core_key_q   <= '0;
      core_reset_q <= 1'b1;
      core_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_cipher_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      core_plain_q <= core_plain_d;
      core_key_q   <= core_key_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_cipher_q <= rsp_cipher_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (core_done || tmo_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready[owner_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    core_plain_d = core_plain_q;
    core_key_d   = core_key_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_cipher_d = rsp_cipher_q;
    // A timeout also pulses core_reset to flush the stuck core.
    core_reset_d = (state_d == ST_LOAD) || tmo_hit;
    core_start_d = (state_d == ST_START);

    if (accept) begin
      owner_d      = grant_idx;
      rr_ptr_d     = grant_idx;
      core_plain_d = req_plain[BORON_BLK_W*int'(grant_idx) +: BORON_BLK_W];
      core_key_d   = req_key[BORON_KEY_W*int'(grant_idx) +: BORON_KEY_W];
    end

    if (state_q == ST_WAIT && (core_done || tmo_hit)) begin
      rsp_cipher_d         = core_done ? core_cipher : '0;
      rsp_valid_d          = '0;
      rsp_valid_d[owner_q] = 1'b1;
    end

    if (state_q == ST_RESP && rsp_ready[owner_q]) begin
      rsp_valid_d = '0;
    end
  end

`ifdef BORON_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // tmo_cnt_q counts completed WAIT cycles; the TIMEOUT-th cycle without done aborts.
  assign tmo_hit = (state_q == ST_WAIT) && !core_done &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == ST_START) tmo_cnt_d = '0;
    else if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (state_q == ST_WAIT && core_done) rsp_err_d = 1'b0;
    else if (tmo_hit) rsp_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid  = rsp_valid_q;
  assign rsp_cipher = rsp_cipher_q;
  assign core_reset = core_reset_q;
  assign core_start = core_start_q;
  assign core_plain = core_plain_q;
  assign core_key   = core_key_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_boron_enc_scheduler.sv
// Randomized self-checking bench for boron_enc_scheduler with a behavioural
// core stand-in and a transaction-level rotation/response model.
module tb_boron_enc_scheduler;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_plain = '0;
  logic [NREQ*80-1:0]   req_key = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready = '0;
  logic [63:0]          rsp_cipher;
  logic                 rsp_err;
  logic                 core_reset;
  logic                 core_start;
  logic [63:0]          core_plain;
  logic [79:0]          core_key;
  logic [63:0]          core_cipher;
  logic                 core_done = 1'b0;
  logic                 busy;

  always #5 clk = ~clk;

  boron_enc_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_plain   (req_plain),
    .req_key     (req_key),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_cipher  (rsp_cipher),
    .rsp_err     (rsp_err),
    .core_reset  (core_reset),
    .core_start  (core_start),
    .core_plain  (core_plain),
    .core_key    (core_key),
    .core_cipher (core_cipher),
    .core_done   (core_done),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: any fixed mixing of plaintext and key will do here.
  function automatic logic [63:0] core_fn(input logic [63:0] p, input logic [79:0] k);
    return {p[31:0], p[63:32]} ^ k[79:16] ^ {48'h0, k[15:0]} ^ 64'h0B0B_0123_4567_89AB;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Core model: captures operands under core_reset, raises done core_lat cycles after start.
  logic [63:0] m_plain = '0;
  logic [79:0] m_key = '0;
  int          lat_cnt = 0;
  int          core_lat = 1;
  bit          core_hang = 1'b0;

  always @(posedge clk) begin
    if (core_reset) begin
      m_plain   <= core_plain;
      m_key     <= core_key;
      core_done <= 1'b0;
      lat_cnt   <= 0;
    end else if (core_start) begin
      if (core_hang) lat_cnt <= 0;
      else if (core_lat == 0) core_done <= 1'b1;
      else lat_cnt <= core_lat;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) core_done <= 1'b1;
    end
  end

  assign core_cipher = core_fn(m_plain, m_key);

  // Requester bookkeeping: a requester holds valid while it has jobs left.
  int          jobs_left [NREQ];
  logic [63:0] plain_r [NREQ];
  logic [79:0] key_r [NREQ];
  int          last_grant = NREQ - 1;

  task automatic drive_req(input int i, input logic [63:0] p, input logic [79:0] k);
    plain_r[i]           = p;
    key_r[i]             = k;
    req_plain[64*i +: 64] = p;
    req_key[80*i +: 80]   = k;
    req_valid[i]         = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic int exp_grant();
    for (int k = 1; k <= NREQ; k++) begin
      if (jobs_left[(last_grant + k) % NREQ] > 0) return (last_grant + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NREQ; i++) if (jobs_left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_cipher", rsp_cipher, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_plain", core_plain, '0);
    check("rst_core_key", core_key, '0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    last_grant = NREQ - 1;
  endtask

  // One full job: grant, core sequencing, response with optional backpressure.
  task automatic serve_one(input int lat, input int bp, input bit hang);
    int          g;
    int          n;
    logic [63:0] gp;
    logic [79:0] gk;
    core_lat  = lat;
    core_hang = hang;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      check("grant_seen", |req_ready, 1'b1);
      return;
    end
    g = exp_grant();
    if (g < 0) g = 0;
    check("grant", req_ready, onehot(g));
    check("idle_busy", busy, 1'b0);
    check("idle_rsp_valid", rsp_valid, '0);
    gp = plain_r[g];
    gk = key_r[g];

    @(posedge clk);
    #1;
    last_grant = g;
    jobs_left[g]--;
    if (jobs_left[g] > 0) drive_req(g, rnd64(), rnd80());
    else req_valid[g] = 1'b0;

    @(negedge clk);
    check("load_core_reset", core_reset, 1'b1);
    check("load_core_start", core_start, 1'b0);
    check("load_core_plain", core_plain, gp);
    check("load_core_key", core_key, gk);
    check("load_req_ready", req_ready, '0);
    check("load_busy", busy, 1'b1);
    @(negedge clk);
    check("start_core_reset", core_reset, 1'b0);
    check("start_core_start", core_start, 1'b1);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < lat + TIMEOUT + 20);
    check("rsp_latency", n, hang ? TIMEOUT + 1 : lat + 2);
    check("rsp_valid", rsp_valid, onehot(g));
    check("rsp_cipher", rsp_cipher, hang ? 64'h0 : core_fn(gp, gk));
    check("rsp_err", rsp_err, hang);
    if (hang) check("flush_core_reset", core_reset, 1'b1);
    if (rsp_valid == '0) return;

    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      #1 rsp_ready = NREQ'($urandom) & ~onehot(g);
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, onehot(g));
      check("bp_rsp_cipher", rsp_cipher, hang ? 64'h0 : core_fn(gp, gk));
      check("bp_req_ready", req_ready, '0);
    end
    @(posedge clk);
    #1 rsp_ready = onehot(g) | NREQ'($urandom);
    @(posedge clk);
    #1 rsp_ready = '0;
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] mask;
    for (int i = 0; i < NREQ; i++) jobs_left[i] = 0;

    // Reset values and single job with zero operands
    apply_reset();
    jobs_left[0] = 1;
    drive_req(0, 64'h0, 80'h0);
    serve_one(1, 0, 1'b0);

    // Contention from the reset pointer: expected order 0,1,0,1
    apply_reset();
    jobs_left[0] = 2;
    jobs_left[1] = 2;
    drive_req(0, rnd64(), rnd80());
    drive_req(1, rnd64(), rnd80());
    for (int j = 0; j < 4; j++) serve_one(int'($urandom_range(0, 3)), 0, 1'b0);

    // Long backpressure
    jobs_left[2] = 1;
    drive_req(2, rnd64(), rnd80());
    serve_one(2, 10, 1'b0);

    // Reset while the core is busy in WAIT; the aborted job never answers
    jobs_left[2] = 1;
    drive_req(2, rnd64(), rnd80());
    core_lat  = 40;
    core_hang = 1'b0;
    n = 0;
    @(negedge clk);
    while (!core_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_core_start", core_start, 1'b1);
    jobs_left[2] = 0;
    req_valid[2] = 1'b0;
    jobs_left[1] = 1;
    drive_req(1, rnd64(), rnd80());
    apply_reset();
    serve_one(2, 0, 1'b0);

    // done already high on WAIT entry
    jobs_left[0] = 1;
    drive_req(0, rnd64(), rnd80());
    serve_one(0, 1, 1'b0);

`ifdef BORON_SCHED_TIMEOUT_EN
    jobs_left[1] = 1;
    drive_req(1, rnd64(), rnd80());
    serve_one(0, 2, 1'b1);
`endif

    // Randomized rounds with mixed request sets
    for (int r = 0; r < 12; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          jobs_left[i] = int'($urandom_range(1, 3));
          drive_req(i, rnd64(), rnd80());
        end
      end
      while (any_pending()) serve_one(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
